// File: rtl/fir_pkg.sv
// Shared defaults, capture FSM state encoding and the saturating-magnitude
// helper for the FIR output capture block.
package fir_pkg;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_FRAME_LEN = 8000;
   localparam int DEF_ADDR_W    = 13;
   localparam int DEF_LATENCY   = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } cap_state_e;

   // |x| for a w-bit signed value carried in 32 bits; -2^(w-1) clamps to 2^(w-1)-1.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned w);
      logic [31:0] max_v;
      logic [31:0] mag_v;
      max_v = (32'd1 << (w - 32'd1)) - 32'd1;
      if (x < 32'sd0) begin
         mag_v = 32'(-x);
      end else begin
         mag_v = 32'(x);
      end
      if (mag_v > max_v) begin
         return max_v;
      end else begin
         return mag_v;
      end
   endfunction

endpackage

// File: rtl/fir_out_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port that
// returns the old word on a same-address collision and zero beyond the frame.
module capture_ram
   import fir_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int FRAME_LEN = DEF_FRAME_LEN,
   parameter int ADDR_W    = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_p,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(FRAME_LEN);

   logic [DATA_W-1:0] mem_q [FRAME_LEN];
   logic [DATA_W-1:0] rd_data_d;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_ok_s;

   // Read mux sees pre-edge contents, which gives read-old-on-collision.
   always_comb begin
      rd_ok_s   = ({1'b0, rd_addr} < DEPTH);
      rd_data_d = {DATA_W{1'b0}};
      if (rd_ok_s) begin
         rd_data_d = mem_q[rd_addr];
      end else begin
         rd_data_d = {DATA_W{1'b0}};
      end
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Registered read data.
   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         rd_data_q <= {DATA_W{1'b0}};
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_out_capture.sv
// Captures one frame of filter output into a circular RAM after discarding the
// chain fill samples. Optional peak tracking: define FIR_CAPTURE_PEAK_EN.
module fir_out_capture
   import fir_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int FRAME_LEN = DEF_FRAME_LEN,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int LATENCY   = DEF_LATENCY
) (
   input  logic                     clk,
   input  logic                     rst_p,
   input  logic                     ena,
   input  logic                     start,
   input  logic                     one_shot,
   input  logic signed [DATA_W-1:0] y_in,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic                     frame_done,
   output logic [7:0]               frame_cnt,
`ifdef FIR_CAPTURE_PEAK_EN
   output logic                     busy,
   output logic [DATA_W-1:0]        peak_abs
`else
   output logic                     busy
`endif
);

   localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0]  LAT_CNT   = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_LEN - 1);
   localparam cap_state_e        ST_ARMED  = (LATENCY == 0) ? ST_CAPTURE : ST_FLUSH;

   cap_state_e        state_d,      state_q;
   logic [CNT_W-1:0]  flush_cnt_d,  flush_cnt_q;
   logic [ADDR_W-1:0] wr_addr_d,    wr_addr_q;
   logic [7:0]        frame_cnt_d,  frame_cnt_q;
   logic              frame_done_d, frame_done_q;
   logic              busy_d,       busy_q;
   logic              we_s;

   // Next-state logic; start overrides every other event in the cycle.
   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      wr_addr_d    = wr_addr_q;
      frame_cnt_d  = frame_cnt_q;
      frame_done_d = 1'b0;
      we_s         = 1'b0;
      if (start) begin
         state_d     = ST_ARMED;
         flush_cnt_d = LAT_CNT;
         wr_addr_d   = {ADDR_W{1'b0}};
      end else if (ena) begin
         case (state_q)
            ST_FLUSH: begin
               if (flush_cnt_q <= CNT_ONE) begin
                  flush_cnt_d = {CNT_W{1'b0}};
                  state_d     = ST_CAPTURE;
               end else begin
                  flush_cnt_d = flush_cnt_q - CNT_ONE;
               end
            end
            ST_CAPTURE: begin
               we_s = 1'b1;
               if (wr_addr_q == ADDR_LAST) begin
                  wr_addr_d    = {ADDR_W{1'b0}};
                  frame_cnt_d  = frame_cnt_q + 8'd1;
                  frame_done_d = 1'b1;
                  if (one_shot) begin
                     state_d = ST_HOLD;
                  end else begin
                     state_d = ST_CAPTURE;
                  end
               end else begin
                  wr_addr_d = wr_addr_q + ADDR_ONE;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      busy_d = (state_d == ST_FLUSH) || (state_d == ST_CAPTURE);
   end

   // Control and status registers.
   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         state_q      <= ST_IDLE;
         flush_cnt_q  <= {CNT_W{1'b0}};
         wr_addr_q    <= {ADDR_W{1'b0}};
         frame_cnt_q  <= 8'd0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         wr_addr_q    <= wr_addr_d;
         frame_cnt_q  <= frame_cnt_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   capture_ram #(
      .DATA_W    (DATA_W),
      .FRAME_LEN (FRAME_LEN),
      .ADDR_W    (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst_p   (rst_p),
      .we      (we_s),
      .wr_addr (wr_addr_q),
      .wr_data (y_in),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

`ifdef FIR_CAPTURE_PEAK_EN
   logic [DATA_W-1:0] peak_d, peak_q, mag_s;

   // Address 0 restarts the running maximum for the new frame.
   always_comb begin
      mag_s  = DATA_W'(sat_abs(32'(y_in), DATA_W));
      peak_d = peak_q;
      if (we_s) begin
         if (wr_addr_q == {ADDR_W{1'b0}}) begin
            peak_d = mag_s;
         end else if (mag_s > peak_q) begin
            peak_d = mag_s;
         end else begin
            peak_d = peak_q;
         end
      end else begin
         peak_d = peak_q;
      end
   end

   // Peak register.
   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         peak_q <= {DATA_W{1'b0}};
      end else begin
         peak_q <= peak_d;
      end
   end

   assign peak_abs = peak_q;
`endif

   assign wr_addr    = wr_addr_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fir_out_capture.sv
// Directed self-checking bench for fir_out_capture (default parameters).
module tb_fir_out_capture;

   localparam int FL = 8000;

   logic               clk;
   logic               rst_p;
   logic               ena;
   logic               start;
   logic               one_shot;
   logic signed [15:0] y_in;
   logic [12:0]        rd_addr;
   logic [15:0]        rd_data;
   logic [12:0]        wr_addr;
   logic               frame_done;
   logic [7:0]         frame_cnt;
   logic               busy;
`ifdef FIR_CAPTURE_PEAK_EN
   logic [15:0]        peak_abs;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int fd_cnt  = 0;

   fir_out_capture #(
      .DATA_W    (16),
      .FRAME_LEN (FL),
      .ADDR_W    (13),
      .LATENCY   (4)
   ) dut (
      .clk        (clk),
      .rst_p      (rst_p),
      .ena        (ena),
      .start      (start),
      .one_shot   (one_shot),
      .y_in       (y_in),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .wr_addr    (wr_addr),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
`ifdef FIR_CAPTURE_PEAK_EN
      .busy       (busy),
      .peak_abs   (peak_abs)
`else
      .busy       (busy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (frame_done) fd_cnt++;
   endtask

   task automatic cyc(input logic en, input logic [15:0] val);
      ena  = en;
      y_in = en ? val : 16'hBEEF;
      tick();
   endtask

   task automatic feed(input int n, input int base);
      for (int i = 0; i < n; i++) cyc(1'b1, 16'(base + i));
   endtask

   task automatic do_start();
      start = 1'b1;
      ena   = 1'b0;
      tick();
      start = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int a, input int exp);
      ena     = 1'b0;
      rd_addr = 13'(a);
      tick();
      check(tag, {16'd0, rd_data}, 32'(exp));
   endtask

   task automatic pulse_reset();
      rst_p = 1'b1;
      tick();
      rst_p = 1'b0;
   endtask

   initial begin
      rst_p = 1'b1; ena = 1'b0; start = 1'b0; one_shot = 1'b1;
      y_in = 16'sd0; rd_addr = 13'd0;
      tick(); tick();
      check("rst_rd_data", {16'd0, rd_data}, 32'd0);
      check("rst_wr_addr", {19'd0, wr_addr}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef FIR_CAPTURE_PEAK_EN
      check("rst_peak", {16'd0, peak_abs}, 32'd0);
`endif
      rst_p = 1'b0;
      tick();

      // One-shot frame with ramp input: 4 fill samples dropped
      fd_cnt = 0;
      do_start();
      check("flush_busy", {31'd0, busy}, 32'd1);
      feed(4, 0);
      check("flush_wr_addr", {19'd0, wr_addr}, 32'd0);
      feed(1, 4);
      check("first_wr_addr", {19'd0, wr_addr}, 32'd1);
      feed(FL - 1, 5);
      check("fd_hi", {31'd0, frame_done}, 32'd1);
      check("os_fd_cnt", 32'(fd_cnt), 32'd1);
      check("os_frame_cnt", {24'd0, frame_cnt}, 32'd1);
      check("os_busy", {31'd0, busy}, 32'd0);
      check("os_wr_addr", {19'd0, wr_addr}, 32'd0);
      cyc(1'b0, 16'd0);
      check("fd_lo", {31'd0, frame_done}, 32'd0);
      feed(100, 9000);
      check("hold_wr_addr", {19'd0, wr_addr}, 32'd0);
      check("hold_fd_cnt", 32'(fd_cnt), 32'd1);
      check("hold_busy", {31'd0, busy}, 32'd0);
      rd_chk("os_ram0", 0, 4);
      rd_chk("os_ram1", 1, 5);
      rd_chk("os_ram7999", FL - 1, 8003);
      rd_chk("rd_oob8000", FL, 0);
      rd_chk("rd_oob8191", 8191, 0);

      // Continuous mode, two frames
      pulse_reset();
      one_shot = 1'b0;
      fd_cnt = 0;
      do_start();
      feed(4 + 2 * FL, 0);
      check("cont_fd_cnt", 32'(fd_cnt), 32'd2);
      check("cont_frame_cnt", {24'd0, frame_cnt}, 32'd2);
      check("cont_busy", {31'd0, busy}, 32'd1);
      check("cont_wr_addr", {19'd0, wr_addr}, 32'd0);
      rd_chk("cont_ram0", 0, 8004);
      rd_chk("cont_ram7999", FL - 1, 16003);

      // Restart via start at wr_addr 3000: frame_cnt untouched
      do_start();
      feed(3004, 0);
      check("pre_restart_wr", {19'd0, wr_addr}, 32'd3000);
      do_start();
      check("restart_wr_addr", {19'd0, wr_addr}, 32'd0);
      check("restart_frame_cnt", {24'd0, frame_cnt}, 32'd2);
      check("restart_busy", {31'd0, busy}, 32'd1);
      feed(9, 500);
      check("restart_wr_addr5", {19'd0, wr_addr}, 32'd5);
      check("restart_fd_cnt", 32'(fd_cnt), 32'd2);
      rd_chk("restart_ram0", 0, 504);
      rd_chk("restart_ram4", 4, 508);
      rd_chk("restart_ram5", 5, 9);

      // ena toggling, then a same-address read/write collision
      do_start();
      for (int i = 0; i < 24; i++) begin
         cyc(1'b1, 16'(1000 + i));
         cyc(1'b0, 16'd0);
      end
      check("tog_wr_addr", {19'd0, wr_addr}, 32'd20);
      rd_addr = 13'd20;
      ena     = 1'b1;
      y_in    = 16'sd1024;
      tick();
      check("collide_old", {16'd0, rd_data}, 32'd24);
      check("collide_wr_addr", {19'd0, wr_addr}, 32'd21);
      for (int a = 0; a <= 20; a++) rd_chk("tog_ram", a, 1004 + a);

      // Asynchronous reset mid-frame
      pulse_reset();
      fd_cnt = 0;
      do_start();
      feed(3004, 0);
      check("abort_wr_pre", {19'd0, wr_addr}, 32'd3000);
      rst_p = 1'b1;
      #2;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_wr_addr", {19'd0, wr_addr}, 32'd0);
      @(posedge clk);
      #1;
      rst_p = 1'b0;
      do_start();
      feed(14, 2000);
      check("abort_wr_after", {19'd0, wr_addr}, 32'd10);
      check("abort_fd_cnt", 32'(fd_cnt), 32'd0);
      check("abort_frame_cnt", {24'd0, frame_cnt}, 32'd0);
      rd_chk("abort_ram0", 0, 2004);
      rd_chk("abort_ram9", 9, 2013);

`ifdef FIR_CAPTURE_PEAK_EN
      pulse_reset();
      one_shot = 1'b1;
      do_start();
      feed(4, 0);
      cyc(1'b1, 16'h8000);
      cyc(1'b1, 16'd1200);
      for (int i = 0; i < FL - 2; i++) cyc(1'b1, 16'd7);
      check("peak_sat", {16'd0, peak_abs}, 32'd32767);
      cyc(1'b0, 16'd0);
      cyc(1'b0, 16'd0);
      check("peak_hold", {16'd0, peak_abs}, 32'd32767);
      do_start();
      feed(4, 0);
      for (int i = 0; i < FL; i++) cyc(1'b1, (i % 2 == 1) ? 16'hFFFB : 16'd5);
      check("peak_five", {16'd0, peak_abs}, 32'd5);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_out_capture.md
# fir_out_capture

Synthesizable output-side counterpart to the FIR stimulus source. Sits after the last chained filter block and consumes its `y_out` stream one sample per enabled clock. Discards the pipeline-fill samples, writes exactly one frame of `FRAME_LEN` results into a circular capture RAM, and exposes them on a registered read port with frame-complete signalling. Lets results be inspected on hardware instead of through simulator display calls.

## Interface
- `DATA_W`, 16, signed sample width.
- `FRAME_LEN`, 8000, samples per frame; matches the source ROM depth.
- `ADDR_W`, 13, capture address width; must satisfy 2^ADDR_W ≥ FRAME_LEN.
- `LATENCY`, 4, enabled samples discarded after each `start` (filter chain fill).

- `clk`  in  1  system clock, rising edge.
- `rst_p`  in  1  asynchronous reset, active-high.
- `ena`  in  1  sample strobe; one `y_in` sample is consumed per cycle when high.
- `start`  in  1  one-cycle pulse; arms or restarts capture.
- `one_shot`  in  1  1 = stop after one frame; 0 = wrap and overwrite continuously.
- `y_in`  in  DATA_W  signed filter output sample.
- `rd_addr`  in  ADDR_W  capture RAM read address.
- `rd_data`  out  DATA_W  registered RAM read data.
- `wr_addr`  out  ADDR_W  next write address.
- `frame_done`  out  1  one-cycle pulse when a full frame has been written.
- `frame_cnt`  out  8  completed-frame count; wraps 255→0.
- `busy`  out  1  high in FLUSH or CAPTURE.
- `peak_abs`  out  DATA_W  (only with macro) peak |sample| of the current frame.

## Operation
- States:
  - IDLE: reset state.
  - FLUSH: discards `LATENCY` enabled samples.
  - CAPTURE: writes samples to RAM.
  - HOLD: one-shot frame complete.
- IDLE→FLUSH on `start`. Loads flush counter with `LATENCY`. Clears `wr_addr`.
- FLUSH: counter decrements on each `ena` cycle. Moves to CAPTURE when it reaches 0. With `LATENCY`=0, `start` goes directly to CAPTURE.
- CAPTURE: on each `ena`, writes `y_in` to RAM[`wr_addr`].
  - `wr_addr` increments and wraps `FRAME_LEN-1`→0.
  - On the write at `FRAME_LEN-1`: `frame_cnt`+1, `frame_done` pulses.
  - If `one_shot`=1, goes to HOLD; otherwise stays in CAPTURE.
- HOLD: no writes. Leaves only on `start`, which goes to FLUSH.
- `start` in any state wins over all other events that cycle. It re-enters FLUSH with `wr_addr`=0 and does not change `frame_cnt`.
- `ena`=0: nothing advances. No writes, no counter changes.
- Read port is independent of capture state.
  - Read and write to the same address in the same cycle: `rd_data` returns the old contents.
  - `rd_addr` ≥ `FRAME_LEN`: `rd_data` = 0.
- Samples are stored bit-exact. No rescaling or saturation.

## Timing
- Reset values:
  - state IDLE
  - `wr_addr`=0, `rd_data`=0, `frame_done`=0, `frame_cnt`=0, `busy`=0, `peak_abs`=0.
- RAM contents are not reset.
- Reset mid-frame: returns immediately to IDLE. Partial frame is abandoned with no `frame_done`.
- Write latency: a sample is present at `y_in` on the rising edge with `ena`=1 and is written on that same edge.
- `frame_done` is high for the cycle after the final write edge.
- `rd_data`: one-cycle latency from `rd_addr`.
- First captured sample is the (`LATENCY`+1)-th enabled sample after `start`.
- `busy` is a registered decode of state; it updates on the same edge as the state change.

## Configuration
- `FIR_CAPTURE_PEAK_EN` defined:
  - Adds `peak_abs`, updated on every CAPTURE write.
  - Computes |`y_in`|, saturating −2^(DATA_W−1) to 2^(DATA_W−1)−1.
  - The write at address 0 loads the peak with that sample's magnitude (no max with the old value).
  - `peak_abs` holds its value through HOLD and IDLE.
- Undefined: `peak_abs` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `fir_pkg` holds:
  - `DATA_W`, `FRAME_LEN`, `ADDR_W` defaults;
  - capture state enum (IDLE, FLUSH, CAPTURE, HOLD);
  - saturating-abs function.
- Sub-module `capture_ram`: simple dual-port RAM.
  - One write port, one registered read port, read-old-on-collision.
  - `FRAME_LEN` × `DATA_W`.

## Test plan
- Reset then `start`, `LATENCY`=4, `ena`=1, `y_in` = 0,1,2,…: RAM[0]=4, RAM[7999]=8003. `frame_done` pulses once; `frame_cnt`=1.
- `one_shot`=1, full frame: state HOLD, `busy`=0. A further 100 samples leave RAM[0]=4 and `wr_addr`=0.
- `one_shot`=0 for two frames: second frame overwrites, so RAM[0]=8004. `frame_cnt`=2 and exactly two `frame_done` pulses.
- `ena` toggling 1/0 every cycle: captured values are only the enabled samples, in order. No duplicates and no gaps.
- `rst_p` pulse at `wr_addr`=3000, then `start`: no `frame_done` for the aborted frame; capture restarts at address 0. A separate `start` at `wr_addr`=3000 likewise restarts at 0 with `frame_cnt` unchanged.
- With `FIR_CAPTURE_PEAK_EN`, samples include −32768 and +1200: `peak_abs`=32767. Next frame of all ±5 gives `peak_abs`=5.
